// File: rtl/irq_dispatch_ctrl_if.sv
// Register-file and memory-write bus between the interrupt dispatcher and
// the SM83 core datapath. The dispatcher is the master: it issues the 16-bit
// register reads/writes and the byte stores used for the PC push.

package irq_dispatch_pkg;
   // 16-bit register-pair selector shared with the core register file
   typedef enum logic [2:0] {
      RR_BC = 3'd0,
      RR_DE = 3'd1,
      RR_HL = 3'd2,
      RR_SP = 3'd3,
      RR_PC = 3'd4
   } register_nn_t;
endpackage

interface irq_dispatch_ctrl_if;
   import irq_dispatch_pkg::*;

   logic         rf_read_rr;
   register_nn_t rf_read_reg_rr;
   logic [15:0]  rf_data_out_rr;
   logic         rf_write_rr;
   register_nn_t rf_write_reg_rr;
   logic [15:0]  rf_data_in_rr;
   logic         mem_we;
   logic [15:0]  mem_addr;
   logic [7:0]   mem_wdata;

   modport master (
      output rf_read_rr,
      output rf_read_reg_rr,
      input  rf_data_out_rr,
      output rf_write_rr,
      output rf_write_reg_rr,
      output rf_data_in_rr,
      output mem_we,
      output mem_addr,
      output mem_wdata
   );

   modport slave (
      input  rf_read_rr,
      input  rf_read_reg_rr,
      output rf_data_out_rr,
      input  rf_write_rr,
      input  rf_write_reg_rr,
      input  rf_data_in_rr,
      input  mem_we,
      input  mem_addr,
      input  mem_wdata
   );
endinterface

// File: rtl/irq_dispatch_ctrl.sv
// SM83 interrupt dispatch sequencer.
// At an opcode-fetch boundary with IME set and an enabled request pending,
// the core is stalled while PC is pushed (high byte first) below SP, SP is
// written back as SP-2, the winning IF bit is acknowledged and PC is loaded
// with the vector. Each state consumes exactly one M-cycle (m_tick).
// The HALT wake-up request is purely combinational and ignores IME.

module irq_dispatch_ctrl
   import irq_dispatch_pkg::*;
#(
   parameter int NUM_IRQ = 5
) (
   input  logic                clk,
   input  logic                rst,
   input  logic                m_tick,
   input  logic                instr_boundary,
   input  logic                ime,
   input  logic                halted,
   input  logic [NUM_IRQ-1:0]  if_in,
   input  logic [NUM_IRQ-1:0]  ie_in,
   output logic                busy,
   output logic                wake,
   output logic                ime_clr,
   output logic [NUM_IRQ-1:0]  irq_ack,
   irq_dispatch_ctrl_if.master bus
);

   typedef enum logic [2:0] {
      IDLE   = 3'd0,
      CAP_SP = 3'd1,
      DEC_SP = 3'd2,
      PUSH_H = 3'd3,
      PUSH_L = 3'd4,
      JUMP   = 3'd5
   } state_t;

   state_t              state_q, state_d;
   logic [15:0]         pc_q, pc_d;
   logic [15:0]         sp_q, sp_d;
   logic [NUM_IRQ-1:0]  pending;

   // SP decrement; 0x0000 wraps to 0xFFFF naturally in 16 bits
   function automatic logic [15:0] sp_dec(input logic [15:0] v);
      return v - 16'd1;
   endfunction

   // Isolate the lowest set request bit (bit 0 has highest priority)
   function automatic logic [NUM_IRQ-1:0] prio_onehot(input logic [NUM_IRQ-1:0] p);
      return p & (~p + {{(NUM_IRQ-1){1'b0}}, 1'b1});
   endfunction

   // Vector 0x0040 + 8*i for the winning bit, 0x0000 when nothing is left
   function automatic logic [15:0] prio_vector(input logic [NUM_IRQ-1:0] p);
      logic [15:0] v;
      v = 16'h0000;
      for (int i = NUM_IRQ - 1; i >= 0; i--) begin
         if (p[i]) begin
            v = 16'h0040 + 16'(8 * i);
         end
      end
      return v;
   endfunction

   assign pending = if_in & ie_in;

   // HALT exit does not depend on IME
   assign wake = halted & (|pending);

   // State and captured PC/SP; reset wins over any tick
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= IDLE;
         pc_q    <= 16'h0000;
         sp_q    <= 16'h0000;
      end else begin
         state_q <= state_d;
         pc_q    <= pc_d;
         sp_q    <= sp_d;
      end
   end

   // Next-state and strobes; strobes exist only in a ticking clk, all idle in reset
   always_comb begin
      state_d             = state_q;
      pc_d                = pc_q;
      sp_d                = sp_q;
      busy                = 1'b0;
      ime_clr             = 1'b0;
      irq_ack             = '0;
      bus.rf_read_rr      = 1'b0;
      bus.rf_read_reg_rr  = RR_BC;
      bus.rf_write_rr     = 1'b0;
      bus.rf_write_reg_rr = RR_BC;
      bus.rf_data_in_rr   = 16'h0000;
      bus.mem_we          = 1'b0;
      bus.mem_addr        = 16'h0000;
      bus.mem_wdata       = 8'h00;

      if (!rst) begin
         busy = (state_q != IDLE);

         if (m_tick) begin
            unique case (state_q)
               IDLE: begin
                  if (ime && instr_boundary && (|pending)) begin
                     bus.rf_read_rr     = 1'b1;
                     bus.rf_read_reg_rr = RR_PC;
                     pc_d               = bus.rf_data_out_rr;
                     ime_clr            = 1'b1;
                     state_d            = CAP_SP;
                  end
               end

               CAP_SP: begin
                  bus.rf_read_rr     = 1'b1;
                  bus.rf_read_reg_rr = RR_SP;
                  sp_d               = bus.rf_data_out_rr;
                  state_d            = DEC_SP;
               end

               DEC_SP: begin
                  sp_d    = sp_dec(sp_q);
                  state_d = PUSH_H;
               end

               PUSH_H: begin
                  bus.mem_we    = 1'b1;
                  bus.mem_addr  = sp_q;
                  bus.mem_wdata = pc_q[15:8];
                  sp_d          = sp_dec(sp_q);
                  state_d       = PUSH_L;
               end

               PUSH_L: begin
                  // The high-byte store may have hit IE (0xFFFF), so the
                  // winner is chosen from pending as it stands right now.
                  bus.mem_we          = 1'b1;
                  bus.mem_addr        = sp_q;
                  bus.mem_wdata       = pc_q[7:0];
                  bus.rf_write_rr     = 1'b1;
                  bus.rf_write_reg_rr = RR_SP;
                  bus.rf_data_in_rr   = sp_q;
                  irq_ack             = prio_onehot(pending);
                  pc_d                = prio_vector(pending);
                  state_d             = JUMP;
               end

               JUMP: begin
                  bus.rf_write_rr     = 1'b1;
                  bus.rf_write_reg_rr = RR_PC;
                  bus.rf_data_in_rr   = pc_q;
                  state_d             = IDLE;
               end

               default: begin
                  state_d = IDLE;
               end
            endcase
         end
      end
   end

endmodule

// File: tb/tb_irq_dispatch_ctrl.sv
// Bench for irq_dispatch_ctrl: a small core model (PC/SP register pair and
// byte-store log) wraps the dispatcher; each dispatch is compared against the
// architectural outcome of an SM83 interrupt entry.

module tb_irq_dispatch_ctrl;
   import irq_dispatch_pkg::*;

   localparam int NUM_IRQ = 5;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic         rst;
   logic         m_tick;
   logic         instr_boundary;
   logic         ime;
   logic         halted;
   logic [4:0]   if_r;
   logic [4:0]   ie_r;
   logic         busy;
   logic         wake;
   logic         ime_clr;
   logic [4:0]   irq_ack;

   irq_dispatch_ctrl_if bus();

   irq_dispatch_ctrl #(.NUM_IRQ(NUM_IRQ)) dut (
      .clk            (clk),
      .rst            (rst),
      .m_tick         (m_tick),
      .instr_boundary (instr_boundary),
      .ime            (ime),
      .halted         (halted),
      .if_in          (if_r),
      .ie_in          (ie_r),
      .busy           (busy),
      .wake           (wake),
      .ime_clr        (ime_clr),
      .irq_ack        (irq_ack),
      .bus            (bus)
   );

   // Core register file model: PC and SP only
   logic [15:0] core_pc, core_sp, load_pc, load_sp;
   logic        load_en;

   always @(posedge clk) begin
      if (load_en) begin
         core_pc <= load_pc;
         core_sp <= load_sp;
      end else if (bus.rf_write_rr) begin
         if (bus.rf_write_reg_rr == RR_PC) core_pc <= bus.rf_data_in_rr;
         else if (bus.rf_write_reg_rr == RR_SP) core_sp <= bus.rf_data_in_rr;
      end
   end

   assign bus.rf_data_out_rr = !bus.rf_read_rr ? 16'h0000 :
                               (bus.rf_read_reg_rr == RR_PC) ? core_pc :
                               (bus.rf_read_reg_rr == RR_SP) ? core_sp : 16'hDEAD;

   int n_checks = 0;
   int n_fail   = 0;

   task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
      end
   endtask

   // Reference: vector for highest-priority (lowest index) request
   function automatic logic [15:0] ref_vector(input logic [4:0] p);
      logic [15:0] v;
      logic        found;
      v = 16'h0000;
      found = 1'b0;
      for (int i = 0; i < 5; i++) begin
         if (p[i] && !found) begin
            v = 16'h0040 + 16'(i * 8);
            found = 1'b1;
         end
      end
      return v;
   endfunction

   function automatic logic [4:0] ref_ack(input logic [4:0] p);
      logic [4:0] a;
      logic       found;
      a = 5'b0;
      found = 1'b0;
      for (int i = 0; i < 5; i++) begin
         if (p[i] && !found) begin
            a = 5'(1) << i;
            found = 1'b1;
         end
      end
      return a;
   endfunction

   // One complete interrupt-entry attempt with the given core state
   task automatic run_case(input string name, input logic [15:0] pc0, input logic [15:0] sp0,
                           input logic [4:0] ifv, input logic [4:0] iev, input logic ime0,
                           input logic halt0, input int period, input bit drop_ie, input bit do_rst);
      logic [23:0] wr_q[$];
      logic        exp_start;
      logic [4:0]  pend_l;
      logic [4:0]  ack_v;
      int          ack_n, busy_n, clr_n, bad, ticks;
      bit          started, done, clr_ime, clr_ie, rst_done, strobes;

      exp_start = ime0 && ((ifv & iev) != 5'b0);
      pend_l    = ifv & (drop_ie ? 5'b0 : iev);
      ack_v = 5'b0; ack_n = 0; busy_n = 0; clr_n = 0; bad = 0; ticks = 0;
      started = 0; done = 0; clr_ime = 0; clr_ie = 0; rst_done = 0;

      @(negedge clk);
      load_en = 1'b1; load_pc = pc0; load_sp = sp0;
      m_tick = 1'b0; ime = 1'b0; instr_boundary = 1'b0; rst = 1'b0;
      if_r = ifv; ie_r = iev; halted = halt0;
      @(negedge clk);
      load_en = 1'b0;

      for (int c = 0; c < 12 * period + 4 && !done; c++) begin
         if (c != 0) @(negedge clk);
         if (clr_ime) ime = 1'b0;
         if (clr_ie) ie_r = 5'b0;
         m_tick = ((c % period) == 0);
         if (c == 0) begin
            ime = ime0;
            instr_boundary = 1'b1;
         end
         if (do_rst && ticks == 3 && !m_tick && !rst_done) begin
            rst = 1'b1;
            rst_done = 1;
         end else begin
            rst = 1'b0;
         end
         #1;
         if (c == 0) check_val({name, ":wake"}, 32'(wake), 32'(halt0 & (|(ifv & iev))));
         strobes = bus.mem_we | bus.rf_read_rr | bus.rf_write_rr | ime_clr | (|irq_ack);
         if (strobes && !m_tick) bad++;
         if (ime_clr) begin clr_n++; started = 1; clr_ime = 1; end
         if (busy) busy_n++;
         if (bus.mem_we) begin
            wr_q.push_back({bus.mem_addr, bus.mem_wdata});
            if (drop_ie) clr_ie = 1;
         end
         if (irq_ack != 5'b0) begin ack_n++; ack_v = irq_ack; end
         if (started && m_tick && !rst) ticks++;
         if (started && !busy && !ime_clr) done = 1;
      end

      @(negedge clk);
      rst = 1'b0;
      m_tick = 1'b1;
      #1;
      check_val({name, ":idle_busy"}, 32'(busy), 32'd0);
      check_val({name, ":tick_align"}, 32'(bad), 32'd0);
      check_val({name, ":started"}, 32'(done), 32'(exp_start));
      check_val({name, ":ime_clr_n"}, 32'(clr_n), exp_start ? 32'd1 : 32'd0);

      if (do_rst) begin
         check_val({name, ":rst_writes"}, 32'(wr_q.size()), 32'd0);
         check_val({name, ":rst_pc"}, 32'(core_pc), 32'(pc0));
         check_val({name, ":rst_sp"}, 32'(core_sp), 32'(sp0));
         check_val({name, ":rst_ack_n"}, 32'(ack_n), 32'd0);
      end else if (exp_start) begin
         check_val({name, ":busy_clks"}, 32'(busy_n), 32'(5 * period));
         check_val({name, ":wr_n"}, 32'(wr_q.size()), 32'd2);
         if (wr_q.size() == 2) begin
            check_val({name, ":wr_hi"}, 32'(wr_q[0]), 32'({16'(sp0 - 16'd1), pc0[15:8]}));
            check_val({name, ":wr_lo"}, 32'(wr_q[1]), 32'({16'(sp0 - 16'd2), pc0[7:0]}));
         end
         check_val({name, ":sp"}, 32'(core_sp), 32'(16'(sp0 - 16'd2)));
         check_val({name, ":pc"}, 32'(core_pc), 32'(ref_vector(pend_l)));
         check_val({name, ":ack_n"}, 32'(ack_n), (pend_l != 5'b0) ? 32'd1 : 32'd0);
         check_val({name, ":ack"}, 32'(ack_v), 32'(ref_ack(pend_l)));
      end else begin
         check_val({name, ":busy_clks"}, 32'(busy_n), 32'd0);
         check_val({name, ":wr_n"}, 32'(wr_q.size()), 32'd0);
         check_val({name, ":pc"}, 32'(core_pc), 32'(pc0));
         check_val({name, ":sp"}, 32'(core_sp), 32'(sp0));
      end
      m_tick = 1'b0;
   endtask

   initial begin
      int per_tbl[4];
      per_tbl = '{1, 2, 3, 4};
      rst = 1'b1; m_tick = 1'b1; instr_boundary = 1'b1; ime = 1'b1; halted = 1'b1;
      if_r = 5'h01; ie_r = 5'h01; load_en = 1'b0; load_pc = 16'h0; load_sp = 16'h0;
      repeat (3) @(negedge clk);
      #1;
      // Start conditions are all present, yet reset must keep everything quiet
      check_val("rst:busy", 32'(busy), 32'd0);
      check_val("rst:ime_clr", 32'(ime_clr), 32'd0);
      check_val("rst:irq_ack", 32'(irq_ack), 32'd0);
      check_val("rst:rf_read", 32'(bus.rf_read_rr), 32'd0);
      check_val("rst:rf_write", 32'(bus.rf_write_rr), 32'd0);
      check_val("rst:mem_we", 32'(bus.mem_we), 32'd0);
      check_val("rst:mem_addr", 32'(bus.mem_addr), 32'd0);
      check_val("rst:wake", 32'(wake), 32'd1);
      rst = 1'b0; m_tick = 1'b0; ime = 1'b0;

      run_case("vblank",   16'h1234, 16'hFFFE, 5'h01, 5'h01, 1'b1, 1'b0, 1, 1'b0, 1'b0);
      run_case("prio",     16'hABCD, 16'hC000, 5'h1F, 5'h14, 1'b1, 1'b0, 1, 1'b0, 1'b0);
      run_case("sp_wrap",  16'h5678, 16'h0001, 5'h02, 5'h02, 1'b1, 1'b0, 1, 1'b0, 1'b0);
      run_case("ie_clob",  16'h2345, 16'h0000, 5'h10, 5'h10, 1'b1, 1'b0, 1, 1'b1, 1'b0);
      run_case("halt_wk",  16'h0100, 16'hDFF0, 5'h02, 5'h02, 1'b0, 1'b1, 1, 1'b0, 1'b0);
      run_case("tick4",    16'h4321, 16'hD000, 5'h08, 5'h08, 1'b1, 1'b0, 4, 1'b0, 1'b0);
      run_case("rst_mid",  16'h7777, 16'hE000, 5'h04, 5'h04, 1'b1, 1'b0, 2, 1'b0, 1'b1);
      run_case("restart",  16'h8888, 16'hE000, 5'h04, 5'h04, 1'b1, 1'b0, 1, 1'b0, 1'b0);

      for (int n = 0; n < 30; n++) begin
         run_case($sformatf("rnd%0d", n),
                  16'($urandom), 16'($urandom),
                  5'($urandom), 5'($urandom),
                  1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 1)),
                  per_tbl[$urandom_range(0, 3)], 1'($urandom_range(0, 1)), 1'b0);
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
